// File: rtl/wisard_ram_discriminator.sv
// WiSARD discriminator: one RAM node per frame word, 2-stage hit/new-bit scoring, clear sweep.
// Define WISARD_RAM_INIT_CLEAR_EN to run a full clear sweep automatically when rst is released.
module wisard_ram_discriminator #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_RAMS      = 8,
  parameter int SCORE_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     train,
  input  logic                     sop,
  input  logic                     sink_valid,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     clear,
  output logic                     busy,
  output logic [SCORE_WIDTH-1:0]   score,
  output logic                     score_valid,
  output logic                     error
);

  localparam int IDX_W = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RAMS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] SWEEP_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] SWEEP_LAST = {ADDRESS_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  function automatic logic [SCORE_WIDTH-1:0] ext_bit(input logic b);
    return {{(SCORE_WIDTH-1){1'b0}}, b};
  endfunction

  state_t                   state_r, state_n_s;
  logic [IDX_W-1:0]         ram_idx_r, ram_idx_n_s, word_idx_s;
  logic [ADDRESS_WIDTH-1:0] sweep_r, sweep_n_s;
  logic                     train_r, train_eff_s, clear_req_s;
  logic                     accept_s, first_s, last_s, kill_s, err_s;
  logic [NUM_RAMS-1:0]      mem_r [DEPTH];
  logic                     cell_s;
  logic                     s1_v_r, s1_first_r, s1_last_r, s1_bit_r;
  logic [SCORE_WIDTH-1:0]   acc_r, sum_s;

`ifdef WISARD_RAM_INIT_CLEAR_EN
  logic init_clr_r;

  // One-shot clear request on the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) init_clr_r <= 1'b1;
    else     init_clr_r <= 1'b0;
  end

  assign clear_req_s = clear | init_clr_r;
`else
  assign clear_req_s = clear;
`endif

  // Frame sequencing, clear sweep and protocol checks; clear outranks any frame activity.
  always_comb begin
    state_n_s   = state_r;
    ram_idx_n_s = ram_idx_r;
    sweep_n_s   = sweep_r;
    word_idx_s  = ram_idx_r;
    accept_s    = 1'b0;
    first_s     = 1'b0;
    last_s      = 1'b0;
    kill_s      = 1'b0;
    err_s       = 1'b0;
    if (clear_req_s) begin
      state_n_s   = ST_CLEAR;
      ram_idx_n_s = IDX_ZERO;
      sweep_n_s   = {ADDRESS_WIDTH{1'b0}};
      kill_s      = 1'b1;
      err_s       = sink_valid && (state_r == ST_CLEAR);
    end else begin
      case (state_r)
        ST_IDLE, ST_FRAME: begin
          if (sink_valid && sop) begin
            // A sop inside a frame drops the partial frame, including its word in stage 1.
            err_s      = (state_r == ST_FRAME);
            kill_s     = (state_r == ST_FRAME);
            accept_s   = 1'b1;
            first_s    = 1'b1;
            word_idx_s = IDX_ZERO;
            if (NUM_RAMS == 1) begin
              last_s      = 1'b1;
              ram_idx_n_s = IDX_ZERO;
              state_n_s   = ST_IDLE;
            end else begin
              ram_idx_n_s = IDX_ONE;
              state_n_s   = ST_FRAME;
            end
          end else if (sink_valid && (state_r == ST_IDLE)) begin
            err_s = 1'b1;
          end else if (sink_valid) begin
            accept_s = 1'b1;
            if (ram_idx_r == IDX_LAST) begin
              last_s      = 1'b1;
              ram_idx_n_s = IDX_ZERO;
              state_n_s   = ST_IDLE;
            end else begin
              ram_idx_n_s = ram_idx_r + IDX_ONE;
            end
          end else begin
            accept_s = 1'b0;
          end
        end
        ST_CLEAR: begin
          err_s     = sink_valid;
          sweep_n_s = sweep_r + SWEEP_ONE;
          if (sweep_r == SWEEP_LAST) state_n_s = ST_IDLE;
          else                       state_n_s = ST_CLEAR;
        end
        default: begin
          state_n_s   = ST_IDLE;
          ram_idx_n_s = IDX_ZERO;
        end
      endcase
    end
  end

  assign train_eff_s = first_s ? train : train_r;
  assign cell_s      = mem_r[addr][word_idx_s];

  // Control state, busy and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ram_idx_r <= IDX_ZERO;
      sweep_r   <= {ADDRESS_WIDTH{1'b0}};
      train_r   <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      ram_idx_r <= ram_idx_n_s;
      sweep_r   <= sweep_n_s;
      train_r   <= train_eff_s;
      busy      <= (state_n_s == ST_CLEAR);
      error     <= err_s;
    end
  end

  // RAM cells: one address row across all nodes zeroed per sweep cycle, single-bit training writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == ST_CLEAR) mem_r[sweep_r] <= {NUM_RAMS{1'b0}};
      else if (accept_s && train_eff_s) mem_r[addr][word_idx_s] <= 1'b1;
    end
  end

  // Stage 1: the counted bit is the hit in recognition, the newly-set flag in training.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r     <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_bit_r   <= 1'b0;
    end else begin
      s1_v_r     <= accept_s;
      s1_first_r <= first_s;
      s1_last_r  <= last_s;
      s1_bit_r   <= train_eff_s ? ~cell_s : cell_s;
    end
  end

  always_comb begin
    sum_s = acc_r;
    if (s1_first_r) sum_s = ext_bit(s1_bit_r);
    else            sum_s = acc_r + ext_bit(s1_bit_r);
  end

  // Stage 2: accumulate and publish the frame score on its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {SCORE_WIDTH{1'b0}};
      score       <= {SCORE_WIDTH{1'b0}};
      score_valid <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      if (s1_v_r && !kill_s) begin
        acc_r <= sum_s;
        if (s1_last_r) begin
          score       <= sum_s;
          score_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wisard_ram_discriminator.sv
// Self-checking bench for wisard_ram_discriminator: directed test-plan steps plus random
// traffic, all compared every cycle against a frame-level reference model.
module tb_wisard_ram_discriminator;
  localparam int NR = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, train, sop, sink_valid, clear;
  logic [AW-1:0] addr;
  logic          busy, score_valid, error;
  logic [3:0]    score;

  wisard_ram_discriminator #(.ADDRESS_WIDTH(AW), .NUM_RAMS(NR), .SCORE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .train(train), .sop(sop), .sink_valid(sink_valid),
    .addr(addr), .clear(clear), .busy(busy), .score(score),
    .score_valid(score_valid), .error(error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: cell contents per RAM node plus frame/clear progress counters.
  bit model_mem [NR][1 << AW];
  bit exp_sv    [8192];
  int exp_score [8192];
  int cyc = 0;
  int m_word = 0, m_clear_left = 0, m_score = 0, m_last_score = 0;
  bit m_train = 1'b0, m_init = 1'b0;

  int n_sv = 0, n_err = 0, n_busy = 0, obs_score = 0, sv_cyc = 0, sv_prev = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock of stimulus; the model predicts what this edge must produce, then outputs are checked.
  task automatic step(input bit v, input bit s, input logic [AW-1:0] a, input bit t, input bit c);
    bit exp_err;
    bit ce;
    bit hit;
    exp_err = 1'b0;
    ce      = c | m_init;
    m_init  = 1'b0;
    if (ce) begin
      exp_err      = v && (m_clear_left > 0);
      m_clear_left = 1 << AW;
      m_word       = 0;
      exp_sv[cyc + 1] = 1'b0;
      for (int r = 0; r < NR; r++)
        for (int i = 0; i < (1 << AW); i++) model_mem[r][i] = 1'b0;
    end else if (m_clear_left > 0) begin
      exp_err = v;
      m_clear_left--;
    end else if (v) begin
      if (s) begin
        exp_err = (m_word > 0);
        m_word  = 0;
        m_score = 0;
        m_train = t;
      end
      if (!s && m_word == 0) begin
        exp_err = 1'b1;
      end else begin
        hit = model_mem[m_word][a];
        if (m_train) begin
          if (!hit) m_score++;
          model_mem[m_word][a] = 1'b1;
        end else if (hit) begin
          m_score++;
        end
        m_word++;
        if (m_word == NR) begin
          m_word = 0;
          exp_sv[cyc + 2]    = 1'b1;
          exp_score[cyc + 2] = m_score;
        end
      end
    end
    sink_valid = v; sop = s; addr = a; train = t; clear = c;
    @(posedge clk);
    cyc++;
    #1;
    check("error", error, exp_err);
    check("busy", busy, m_clear_left > 0);
    check("score_valid", score_valid, exp_sv[cyc]);
    if (exp_sv[cyc]) m_last_score = exp_score[cyc];
    check("score", score, m_last_score);
    if (score_valid) begin n_sv++; obs_score = score; sv_prev = sv_cyc; sv_cyc = cyc; end
    if (error) n_err++;
    if (busy) n_busy++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Word k of the frame takes its address from av[5k +: 5].
  task automatic frame(input bit t, input logic [39:0] av);
    for (int k = 0; k < NR; k++) step(1'b1, k == 0, av[k*5 +: 5], t, 1'b0);
  endtask

  initial begin
    logic [39:0] a07, a3, amix;
    int e0, s0, t_last;
    a07  = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    a3   = {8{5'd3}};
    amix = {{5{5'd3}}, {3{5'd4}}};
    rst = 1'b1; train = 1'b0; sop = 1'b0; sink_valid = 1'b0; clear = 1'b0; addr = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_busy", busy, 1'b0);
      check("reset_score", score, 4'd0);
      check("reset_score_valid", score_valid, 1'b0);
      check("reset_error", error, 1'b0);
    end
    rst = 1'b0;
`ifdef WISARD_RAM_INIT_CLEAR_EN
    m_init = 1'b1;
    n_busy = 0;
    idle(34);
    check("init_busy_len", n_busy, 32);
    frame(1'b0, a07); idle(3);
    check("init_rec_score", obs_score, 0);
`endif

    // Explicit clear, then recognition of an empty discriminator.
    n_busy = 0;
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(34);
    check("clear_busy_len", n_busy, 32);
    e0 = n_err; s0 = n_sv;
    frame(1'b0, a07); t_last = cyc - 1; idle(3);
    check("rec0_score", obs_score, 0);
    check("rec0_latency", sv_cyc - t_last, 2);
    check("rec0_errors", n_err - e0, 0);
    check("rec0_pulses", n_sv - s0, 1);

    frame(1'b1, a3); idle(3);
    check("train1_score", obs_score, 8);
    frame(1'b1, a3); idle(3);
    check("train2_score", obs_score, 0);
    frame(1'b0, a3); idle(3);
    check("rec3_score", obs_score, 8);
    frame(1'b0, amix); idle(3);
    check("recmix_score", obs_score, 5);

    // Back-to-back frames.
    s0 = n_sv;
    frame(1'b0, a3); frame(1'b0, amix); idle(3);
    check("b2b_pulses", n_sv - s0, 2);
    check("b2b_spacing", sv_cyc - sv_prev, 8);
    check("b2b_score2", obs_score, 5);

    // Restart with sop at word 4.
    e0 = n_err; s0 = n_sv;
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 5'd3, 1'b0, 1'b0);
    frame(1'b0, a3); t_last = cyc - 1; idle(3);
    check("abort_errors", n_err - e0, 1);
    check("abort_pulses", n_sv - s0, 1);
    check("abort_latency", sv_cyc - t_last, 2);
    check("abort_score", obs_score, 8);

    // Clear at word 2 with traffic during the sweep.
    step(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    n_busy = 0; e0 = n_err; s0 = n_sv;
    step(1'b1, 1'b0, 5'd3, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(i < 10, 1'b0, 5'd3, 1'b0, 1'b0);
    check("clr_busy_len", n_busy, 32);
    check("clr_errors", n_err - e0, 10);
    check("clr_pulses", n_sv - s0, 0);
    frame(1'b0, a3); idle(3);
    check("clr_rec_score", obs_score, 0);

    // Stray word in IDLE.
    e0 = n_err;
    step(1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
    idle(1);
    check("idle_stray_error", n_err - e0, 1);
    frame(1'b1, amix); idle(3);
    check("idle_after_stray", obs_score, 8);

    // Random traffic: gaps, restarts, rare clears, small address range for frequent hits.
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_word == 0) s = v && ($urandom_range(0, 5) != 0);
      else             s = v && ($urandom_range(0, 24) == 0);
      step(v, s, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 299) == 0);
    end
    idle(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
